ovl_checker_ctrl: RTL and testbench

- Central controller for a bank of NUM_CHK OVL checkers (ovl_always and friends).
- Drives each checker's enable input and holds them off for ARM_DLY cycles after global enable.
- Captures checker fires into sticky pending bits and keeps saturating per-checker fire counters.
- Round-robin arbitrates the pending fires onto one valid/ready report channel read by the testbench monitor.

---
 rtl/ovl_checker_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ovl_checker_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_checker_ctrl.sv
// ovl_checker_ctrl
//   Controller for a bank of NUM_CHK OVL checkers. It sequences checker enables
//   (IDLE -> ARMING for ARM_DLY cycles -> ACTIVE). It latches checker fires into
//   sticky pending bits and keeps a saturating fire counter per checker. Pending
//   fires are reported one at a time on a valid/ready channel, picked round-robin.
//
//   Optional build macro: OVL_CHECKER_CTRL_HALT_EN
//     Adds the sticky 'halt' output. The first accepted report parks the FSM in
//     HALTED. In HALTED the checkers are disabled and no new fires are captured,
//     but pending fires are still reported.
//
// Ports
//   clock, reset       rising-edge clock, async active-low reset
//   global_en          master enable, 0 returns to IDLE and flushes pending fires
//   chk_mask           per-checker permit
//   chk_fire           checker fire outputs
//   clr_cnt            synchronous clear of all fire counters
//   chk_enable         registered enable to each checker
//   armed              high while ACTIVE
//   rpt_valid/ready    report handshake
//   rpt_id, rpt_count  reported checker and its counter snapshot at grant
//   halt               (macro only) sticky stop after first accepted report

module ovl_checker_ctrl_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cap,
    input  logic             ack,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic             pending,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            // A fire in the handshake cycle wins over the ack, so it is reported again.
            if (flush)    pending <= 1'b0;
            else if (cap) pending <= 1'b1;
            else if (ack) pending <= 1'b0;

            if (clr_cnt)                          cnt <= cap ? CNT_W'(1) : '0;
            else if (cap && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
        end
    end
endmodule

module ovl_checker_ctrl #(
    parameter int NUM_CHK = 4,
    parameter int ARM_DLY = 2,
    parameter int CNT_W   = 8,
    localparam int ID_W   = $clog2(NUM_CHK)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               global_en,
    input  logic [NUM_CHK-1:0] chk_mask,
    input  logic [NUM_CHK-1:0] chk_fire,
    input  logic               clr_cnt,
    output logic [NUM_CHK-1:0] chk_enable,
    output logic               armed,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id,
    output logic [CNT_W-1:0]   rpt_count
`ifdef OVL_CHECKER_CTRL_HALT_EN
    ,
    output logic               halt
`endif
);
`ifdef OVL_CHECKER_CTRL_HALT_EN
    typedef enum logic [1:0] {S_IDLE, S_ARMING, S_ACTIVE, S_HALTED} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ARMING, S_ACTIVE} state_t;
`endif

    state_t                          state;
    logic [7:0]                      arm_cnt;
    logic [ID_W-1:0]                 rr_ptr;
    logic [NUM_CHK-1:0]              pending;
    logic [NUM_CHK-1:0][CNT_W-1:0]   cnt;
    logic [NUM_CHK-1:0]              cap;
    logic [NUM_CHK-1:0]              ack;
    logic                            hs;
    logic                            flush;
    logic                            is_halted;
    logic                            grant_vld;
    logic [ID_W-1:0]                 grant_id;
    logic [ID_W-1:0]                 idx;

`ifdef OVL_CHECKER_CTRL_HALT_EN
    assign is_halted = halt;
`else
    assign is_halted = 1'b0;
`endif

    // Once halted, global_en is ignored, so no flush occurs.
    assign flush = !global_en && !is_halted;
    assign hs    = rpt_valid && rpt_ready;
    assign cap   = (state == S_ACTIVE) ? (chk_fire & chk_mask) : '0;
    assign ack   = hs ? (NUM_CHK'(1) << rpt_id) : '0;

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_lane
        ovl_checker_ctrl_lane #(.CNT_W(CNT_W)) u_lane (
            .clock   (clock),
            .reset   (reset),
            .cap     (cap[i]),
            .ack     (ack[i]),
            .flush   (flush),
            .clr_cnt (clr_cnt),
            .pending (pending[i]),
            .cnt     (cnt[i])
        );
    end

    // First pending bit at or after rr_ptr+1, with wrap-around.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_CHK; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_CHK);
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            arm_cnt    <= '0;
            chk_enable <= '0;
            armed      <= 1'b0;
            rpt_valid  <= 1'b0;
            rpt_id     <= '0;
            rpt_count  <= '0;
            rr_ptr     <= ID_W'(NUM_CHK - 1);
`ifdef OVL_CHECKER_CTRL_HALT_EN
            halt       <= 1'b0;
`endif
        end else begin
            // Report channel. The pending bits being flushed must not be granted.
            if (hs) begin
                rpt_valid <= 1'b0;
            end else if (!rpt_valid && grant_vld && !flush) begin
                rpt_valid <= 1'b1;
                rpt_id    <= grant_id;
                rpt_count <= cnt[grant_id];
                rr_ptr    <= grant_id;
            end

`ifdef OVL_CHECKER_CTRL_HALT_EN
            if (hs && !halt) begin
                state      <= S_HALTED;
                halt       <= 1'b1;
                chk_enable <= '0;
                armed      <= 1'b0;
            end else
`endif
            if (flush) begin
                state      <= S_IDLE;
                chk_enable <= '0;
                armed      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ARM_DLY == 0) begin
                            state      <= S_ACTIVE;
                            chk_enable <= chk_mask;
                            armed      <= 1'b1;
                        end else begin
                            state      <= S_ARMING;
                            arm_cnt    <= 8'(ARM_DLY);
                            chk_enable <= '0;
                            armed      <= 1'b0;
                        end
                    end
                    S_ARMING: begin
                        if (arm_cnt == 8'd1) begin
                            state      <= S_ACTIVE;
                            chk_enable <= chk_mask;
                            armed      <= 1'b1;
                        end else begin
                            arm_cnt    <= arm_cnt - 8'd1;
                        end
                    end
                    S_ACTIVE: begin
                        chk_enable <= chk_mask;
                        armed      <= 1'b1;
                    end
                    default: begin
                        chk_enable <= '0;
                        armed      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ovl_checker_ctrl.sv
module tb_ovl_checker_ctrl;
    localparam int NUM_CHK = 4;
    localparam int ARM_DLY = 2;
    localparam int CNT_W   = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       global_en = 1'b0;
    logic [3:0] chk_mask = 4'h0;
    logic [3:0] chk_fire = 4'h0;
    logic       clr_cnt = 1'b0;
    logic       rpt_ready = 1'b0;
    logic [3:0] chk_enable;
    logic       armed;
    logic       rpt_valid;
    logic [1:0] rpt_id;
    logic [7:0] rpt_count;
`ifdef OVL_CHECKER_CTRL_HALT_EN
    logic       halt;
`endif

    ovl_checker_ctrl #(.NUM_CHK(NUM_CHK), .ARM_DLY(ARM_DLY), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .global_en  (global_en),
        .chk_mask   (chk_mask),
        .chk_fire   (chk_fire),
        .clr_cnt    (clr_cnt),
        .chk_enable (chk_enable),
        .armed      (armed),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_id     (rpt_id),
        .rpt_count  (rpt_count)
`ifdef OVL_CHECKER_CTRL_HALT_EN
        ,
        .halt       (halt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain counters and arrays. m_arm is the number of cycles
    // still to wait before the checkers are enabled (-1 = disabled, 0 = live).
    int         m_arm;
    logic [3:0] m_en;
    bit         m_armed, m_valid;
    int         m_id, m_count, m_ptr;
    bit         m_pend[4];
    int         m_cnt[4];

    function automatic void m_reset();
        m_arm = -1; m_en = 4'h0; m_armed = 0; m_valid = 0;
        m_id = 0; m_count = 0; m_ptr = NUM_CHK - 1;
        for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_cnt[i] = 0; end
    endfunction

    function automatic logic [15:0] obs();
        return {chk_enable, armed, rpt_valid, rpt_id, rpt_count};
    endfunction

    function automatic logic [15:0] mexp();
        return {m_en, m_armed, m_valid, 2'(m_id), 8'(m_count)};
    endfunction

    // Advance one clock: predict from the inputs held now, then move to the next negedge.
    task automatic tick();
        bit hs, active, found;
        bit cap[4];
        bit old_pend[4];
        int old_cnt[4];
        int n_arm, old_id, g;
        active = (m_arm == 0);
        hs = m_valid && rpt_ready;
        old_id = m_id; old_cnt = m_cnt; old_pend = m_pend;
        if (!global_en)     n_arm = -1;
        else if (m_arm < 0) n_arm = ARM_DLY;
        else if (m_arm > 0) n_arm = m_arm - 1;
        else                n_arm = 0;
        if (hs) m_valid = 0;
        else if (!m_valid && global_en) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                g = (m_ptr + k) % 4;
                if (!found && old_pend[g]) begin
                    found = 1; m_valid = 1; m_id = g; m_count = old_cnt[g]; m_ptr = g;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            cap[i] = active && chk_fire[i] && chk_mask[i];
            if (clr_cnt)                     m_cnt[i] = cap[i] ? 1 : 0;
            else if (cap[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            if (!global_en)                  m_pend[i] = 0;
            else if (cap[i])                 m_pend[i] = 1;
            else if (hs && old_id == i)      m_pend[i] = 0;
        end
        m_arm = n_arm;
        m_en = (n_arm == 0) ? chk_mask : 4'h0;
        m_armed = (n_arm == 0);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        m_reset();
        @(negedge clock); @(negedge clock);
        n_checks++;
        if (obs() !== 16'h0) $display("FAIL reset_outputs got %h exp 0000", obs());
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs() !== mexp()) $display("FAIL reset_idle got %h exp %h", obs(), mexp());
        else n_pass++;
    endtask

    task automatic test_arming();
        global_en = 1'b1; chk_mask = 4'hF; chk_fire = 4'hF;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++;
            if (obs() !== mexp()) $display("FAIL arm_model c=%0d got %h exp %h", c, obs(), mexp());
            else n_pass++;
            n_checks++;
            if (c < 3 && (chk_enable !== 4'h0 || armed !== 1'b0))
                $display("FAIL arm_hold c=%0d got en=%h armed=%b exp en=0 armed=0", c, chk_enable, armed);
            else if (c == 3 && (chk_enable !== 4'hF || armed !== 1'b1))
                $display("FAIL arm_live got en=%h armed=%b exp en=f armed=1", chk_enable, armed);
            else n_pass++;
        end
        chk_fire = 4'h0;
        tick(); tick();
        n_checks++;
        if (rpt_valid !== 1'b0) $display("FAIL arm_fire_ignored got valid=%b exp 0", rpt_valid);
        else n_pass++;
    endtask

    task automatic test_single();
        int vcyc = 0;
        rpt_ready = 1'b1; chk_fire = 4'b0001;
        tick();
        chk_fire = 4'h0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (obs() !== mexp()) $display("FAIL single_model c=%0d got %h exp %h", c, obs(), mexp());
            else n_pass++;
            if (rpt_valid) begin
                vcyc++;
                n_checks++;
                if (rpt_id !== 2'd0 || rpt_count !== 8'd1)
                    $display("FAIL single_report got id=%0d cnt=%0d exp id=0 cnt=1", rpt_id, rpt_count);
                else n_pass++;
            end
        end
        n_checks++;
        if (vcyc != 1) $display("FAIL single_valid_len got %0d exp 1", vcyc);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int ids[$];
        rpt_ready = 1'b1; chk_fire = 4'b1010;
        tick();
        chk_fire = 4'h0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (obs() !== mexp()) $display("FAIL rr_model c=%0d got %h exp %h", c, obs(), mexp());
            else n_pass++;
            if (rpt_valid && rpt_ready) ids.push_back(int'(rpt_id));
        end
        n_checks++;
        if (ids.size() != 2 || ids[0] != 1 || ids[1] != 3)
            $display("FAIL rr_order got n=%0d first=%0d exp ids 1,3", ids.size(), ids.size() > 0 ? ids[0] : -1);
        else n_pass++;
        ids.delete();
        chk_fire = 4'b1001;
        tick();
        chk_fire = 4'h0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (obs() !== mexp()) $display("FAIL rr_wrap_model c=%0d got %h exp %h", c, obs(), mexp());
            else n_pass++;
            if (rpt_valid && rpt_ready) ids.push_back(int'(rpt_id));
        end
        n_checks++;
        if (ids.size() != 2 || ids[0] != 0 || ids[1] != 3)
            $display("FAIL rr_wrap got n=%0d first=%0d exp ids 0,3", ids.size(), ids.size() > 0 ? ids[0] : -1);
        else n_pass++;
    endtask

    task automatic test_hold_saturate();
        int bad = 0;
        bit seen = 0;
        rpt_ready = 1'b0; chk_fire = 4'b0100;
        for (int c = 0; c < 300; c++) begin
            clr_cnt = (c == 10);
            tick();
            if (obs() !== mexp()) bad++;
            if (c > 1 && (rpt_valid !== 1'b1 || rpt_id !== 2'd2 || rpt_count !== 8'd1)) bad++;
        end
        clr_cnt = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL hold_stable got %0d bad cycles exp 0", bad);
        else n_pass++;
        rpt_ready = 1'b1;
        tick();
        chk_fire = 4'h0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!seen && rpt_valid) begin
                seen = 1;
                n_checks++;
                if (rpt_id !== 2'd2 || rpt_count !== 8'd255)
                    $display("FAIL hold_saturated got id=%0d cnt=%0d exp id=2 cnt=255", rpt_id, rpt_count);
                else n_pass++;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL hold_rereport got none exp one report within 10 cycles");
        else n_pass++;
        n_checks++;
        if (obs() !== mexp()) $display("FAIL hold_model got %h exp %h", obs(), mexp());
        else n_pass++;
    endtask

    task automatic test_disable();
        int bad = 0;
        rpt_ready = 1'b1; chk_fire = 4'b0100;
        tick();
        global_en = 1'b0; chk_fire = 4'h0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (obs() !== mexp() || rpt_valid !== 1'b0 || chk_enable !== 4'h0 || armed !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL disable_idle got %0d bad cycles exp 0", bad);
        else n_pass++;
        global_en = 1'b1;
        tick(); tick();
        n_checks++;
        if (chk_enable !== 4'h0 || armed !== 1'b0) $display("FAIL rearm_hold got en=%h exp 0", chk_enable);
        else n_pass++;
        tick();
        n_checks++;
        if (chk_enable !== 4'hF || armed !== 1'b1 || rpt_valid !== 1'b0)
            $display("FAIL rearm_live got en=%h armed=%b valid=%b exp f 1 0", chk_enable, armed, rpt_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 500; c++) begin
            global_en = ($urandom_range(0, 39) != 0);
            chk_mask  = 4'($urandom);
            chk_fire  = 4'($urandom) & 4'($urandom);
            clr_cnt   = ($urandom_range(0, 19) == 0);
            rpt_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if (obs() !== mexp()) begin
                bad++;
                if (bad < 5) $display("FAIL random_model c=%0d got %h exp %h", c, obs(), mexp());
            end else n_pass++;
        end
        global_en = 1'b1; chk_mask = 4'hF; chk_fire = 4'h0; clr_cnt = 1'b0;
    endtask

    task automatic test_async_reset();
        int waited = 0;
        rpt_ready = 1'b0;
        while (m_arm != 0 && waited < 10) begin tick(); waited++; end
        chk_fire = 4'b0001;
        tick();
        chk_fire = 4'h0;
        tick();
        n_checks++;
        if (rpt_valid !== 1'b1 || obs() !== mexp())
            $display("FAIL async_pre got %h exp %h", obs(), mexp());
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 16'h0) $display("FAIL async_reset got %h exp 0000", obs());
        else n_pass++;
`ifdef OVL_CHECKER_CTRL_HALT_EN
        n_checks++;
        if (halt !== 1'b0) $display("FAIL async_halt got %b exp 0", halt);
        else n_pass++;
`endif
        m_reset();
        @(negedge clock);
        reset = 1'b1; global_en = 1'b0;
        tick();
        n_checks++;
        if (obs() !== mexp()) $display("FAIL post_reset got %h exp %h", obs(), mexp());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arming();
        test_single();
        test_round_robin();
        test_hold_saturate();
        test_disable();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish exp finish before 2ms");
        $fatal(1);
    end
endmodule
